// File: rtl/rom_loader.sv
// rom_loader: streams a boot image into on-chip ROM, zero-fills short images, then releases the CPU.
module rom_loader #(
  parameter int ROM_SIZE   = 4096,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load_start,
  input  logic [7:0]            load_data,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic                  load_end,
  input  logic                  clk_en,
  input  logic [ADDR_WIDTH-1:0] rom_addr,
  output logic [7:0]            rom_data,
  output logic                  cpu_reset,
  output logic                  load_done,
  output logic                  load_error
);
  localparam logic [ADDR_WIDTH:0] SZ = (ADDR_WIDTH + 1)'(ROM_SIZE);
  typedef enum logic [2:0] {IDLE, LOAD, FILL, DONE, ERROR} state_t;
  state_t              state, state_nx;
  logic [ADDR_WIDTH:0] wcnt, wcnt_nx;
  logic [7:0]          mem [ROM_SIZE];
  logic                we, acc;
  logic [7:0]          wdata;
  assign load_ready = state == LOAD && wcnt < SZ;
  assign acc = load_valid && load_ready;
  // A byte accepted alongside load_end with one slot left completes the image; FILL then just exits.
  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    we       = 1'b0;
    wdata    = load_data;
    if (load_start) begin
      state_nx = LOAD;
      wcnt_nx  = '0;
    end else if (state == LOAD) begin
      we       = acc;
      wcnt_nx  = wcnt + {{ADDR_WIDTH{1'b0}}, acc};
      state_nx = wcnt == SZ                ? DONE  :
                 load_end && wcnt != '0    ? FILL  :
                 load_end && !acc          ? ERROR : LOAD;
    end else if (state == FILL) begin
      we       = wcnt < SZ;
      wdata    = 8'h00;
      wcnt_nx  = wcnt + 1'b1;
      state_nx = wcnt >= SZ - 1'b1 ? DONE : FILL;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wcnt       <= '0;
      cpu_reset  <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      rom_data   <= 8'h00;
    end else begin
      state      <= state_nx;
      wcnt       <= wcnt_nx;
      cpu_reset  <= load_start || state != DONE;
      load_done  <= !load_start && state == DONE;
      load_error <= !load_start && state == ERROR;
      if (clk_en)
        rom_data <= (state == DONE && {1'b0, rom_addr} < SZ) ? mem[rom_addr] : 8'h00;
    end
  end
  // Image storage survives reset so a warm reset keeps the last image bytes.
  always_ff @(posedge clk)
    if (we) mem[wcnt[ADDR_WIDTH-1:0]] <= wdata;
endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: directed checks of load, fill, error, backpressure, restart, reset and clk_en gating.
module tb_rom_loader;
  logic        clk = 1'b0, reset_n = 1'b0, load_start = 1'b0, load_valid = 1'b0;
  logic        load_end = 1'b0, clk_en = 1'b0;
  logic [7:0]  load_data = 8'h00;
  logic [11:0] rom_addr = 12'h000;
  logic        load_ready, cpu_reset, load_done, load_error;
  logic [7:0]  rom_data;
  logic [7:0]  img [4096];
  logic [7:0]  d;
  int          errors = 0, checks = 0;
  int          rc, last, done_at, sent, n, bad;

  rom_loader dut (
    .clk(clk), .reset_n(reset_n), .load_start(load_start), .load_data(load_data),
    .load_valid(load_valid), .load_ready(load_ready), .load_end(load_end),
    .clk_en(clk_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .cpu_reset(cpu_reset), .load_done(load_done), .load_error(load_error)
  );

  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [7:0] q);
    rom_addr = a;
    clk_en = 1'b1;
    step();
    clk_en = 1'b0;
    q = rom_data;
  endtask

  task automatic scan(input string tag);
    int b = 0;
    logic [7:0] q;
    for (int i = 0; i < 4096; i++) begin
      rd(12'(i), q);
      if (q !== img[i]) b++;
    end
    check(tag, b, 0);
  endtask

  task automatic stream(input bit rnd, output int r, output int l, output int dn, output int s);
    r = 0; l = 0; dn = -1; s = 0;
    for (int c = 0; c < 20000; c++) begin
      load_data = s < 4096 ? img[s] : 8'hEE;
      load_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (load_ready) begin
        r++;
        l = c;
        if (load_valid) s++;
      end
      step();
      if (load_done) begin
        dn = c + 1;
        break;
      end
    end
    load_valid = 1'b0;
  endtask

  initial begin
    #12;
    check("rst_ready", load_ready, 0);
    check("rst_rom_data", rom_data, 0);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_done", load_done, 0);
    check("rst_error", load_error, 0);
    reset_n = 1'b1;
    load_valid = 1'b1;
    repeat (3) step();
    load_valid = 1'b0;
    check("idle_ready", load_ready, 0);
    check("idle_cpu_reset", cpu_reset, 1);

    for (int i = 0; i < 4096; i++) img[i] = 8'(i);
    start();
    check("load_cpu_reset", cpu_reset, 1);
    check("load_ready_on", load_ready, 1);
    stream(1'b0, rc, last, done_at, sent);
    check("full_ready_cycles", rc, 4096);
    check("full_done_latency", done_at - last, 3);
    check("full_done", load_done, 1);
    check("full_cpu_reset", cpu_reset, 0);
    check("full_error", load_error, 0);
    rom_addr = 12'h123;
    repeat (3) step();
    check("en_hold_before", rom_data, 8'h00);
    for (int k = 0; k < 8; k++) begin
      clk_en = (k % 4) == 3;
      step();
    end
    clk_en = 1'b0;
    check("en_read_123", rom_data, 8'h23);
    scan("full_scan");

    for (int i = 0; i < 4096; i++) img[i] = i < 16 ? 8'hA5 : 8'h00;
    start();
    load_valid = 1'b1;
    load_data = 8'hA5;
    repeat (16) step();
    load_valid = 1'b0;
    load_end = 1'b1;
    step();
    load_end = 1'b0;
    n = 0;
    while (!load_done && n < 5000) begin
      step();
      n++;
    end
    check("short_fill_cycles", n, 4081);
    rd(12'h00F, d); check("short_00F", d, 8'hA5);
    rd(12'h010, d); check("short_010", d, 8'h00);
    rd(12'hFFF, d); check("short_FFF", d, 8'h00);
    scan("short_scan");

    start();
    check("restart_done_clr", load_done, 0);
    check("restart_cpu_reset", cpu_reset, 1);
    load_end = 1'b1;
    step();
    load_end = 1'b0;
    repeat (2) step();
    check("empty_error", load_error, 1);
    check("empty_done", load_done, 0);
    check("empty_cpu_reset", cpu_reset, 1);
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      rd(12'h00F, d);
      if (d !== 8'h00) bad++;
    end
    check("empty_rom_data", bad, 0);

    for (int i = 0; i < 4096; i++) img[i] = ~8'(i);
    start();
    check("bp_error_clr", load_error, 0);
    stream(1'b1, rc, last, done_at, sent);
    check("bp_sent", sent, 4096);
    check("bp_done_latency", done_at - last, 3);
    load_valid = 1'b1;
    bad = 0;
    repeat (10) begin
      step();
      if (load_ready !== 1'b0) bad++;
    end
    load_valid = 1'b0;
    check("bp_overrun_ready", bad, 0);
    scan("bp_scan");

    for (int i = 0; i < 4096; i++) img[i] = 8'(i + 'h40);
    start();
    load_valid = 1'b1;
    load_data = 8'h11;
    repeat (100) step();
    start();
    stream(1'b0, rc, last, done_at, sent);
    check("restart_ready_cycles", rc, 4096);
    scan("restart_scan");

    rd(12'h005, d);
    check("pre_reset_read", d, 8'h45);
    start();
    load_valid = 1'b1;
    load_data = 8'h77;
    repeat (50) step();
    check("midload_ready", load_ready, 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_ready", load_ready, 0);
    check("async_rom_data", rom_data, 8'h00);
    check("async_cpu_reset", cpu_reset, 1);
    #2 reset_n = 1'b1;
    bad = 0;
    repeat (4) begin
      step();
      if (load_ready !== 1'b0 || cpu_reset !== 1'b1) bad++;
    end
    load_valid = 1'b0;
    check("post_reset_idle", bad, 0);

    start();
    load_valid = 1'b1;
    repeat (50) step();
    load_valid = 1'b0;
    load_end = 1'b1;
    step();
    load_end = 1'b0;
    n = 0;
    while (!load_done && n < 5000) begin
      step();
      n++;
    end
    check("gate_load_done", load_done, 1);
    rd(12'd10, d);
    check("gate_read", d, 8'h77);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      rom_addr = 12'(60 + k);
      step();
      if (rom_data !== 8'h77) bad++;
    end
    check("gate_hold", bad, 0);
    clk_en = 1'b1;
    step();
    clk_en = 1'b0;
    check("gate_update", rom_data, 8'h00);
    rd(12'd10, d);
    #2 reset_n = 1'b0;
    #1;
    check("async_done", load_done, 0);
    check("async_done_cpu_reset", cpu_reset, 1);
    check("async_done_rom_data", rom_data, 8'h00);
    #2 reset_n = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
